// File: rtl/simon_byte_loader.sv
// simon_byte_loader: assembles a byte-wide valid/ready stream into a SIMON 48/96
// key (M*N bits) or data block (2*N bits). Each completed word is offered to the
// core with a level request (newKey/newData). The request is held until the core
// answers with loadKey/loadData.
//
// Ports:
//   clk, nR              clock and asynchronous active-low reset
//   in_valid/in_ready    byte handshake; transfer = in_valid & in_ready
//   in_byte              payload, most-significant byte first
//   in_is_key            type of the transfer, sampled on its first byte
//   in_enc_dec           direction, sampled on the first data byte (1 = encrypt)
//   flush                synchronous abort of a partial transfer
//   loadKey, loadData    core capture acknowledges
//   newKey, newData      level requests to the core
//   enc_dec              direction of the pending or last block
//   KEY                  assembled key, KEY[M-1] holds the first bytes
//   blockIN              assembled block, blockIN[1] holds the first bytes
//   err_nokey            (SIMON_LOADER_KEYLOCK_EN only) one-cycle pulse when a
//                        data transfer is attempted before any key was loaded
//
// Optional feature macro: SIMON_LOADER_KEYLOCK_EN
module simon_byte_loader #(
   parameter int unsigned N  = 24,
   parameter int unsigned M  = 4,
   parameter int unsigned W  = 8,
   parameter int unsigned CB = 5
) (
   input  logic                  clk,
   input  logic                  nR,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_byte,
   input  logic                  in_is_key,
   input  logic                  in_enc_dec,
   input  logic                  flush,
   input  logic                  loadKey,
   input  logic                  loadData,
   output logic                  newKey,
   output logic                  newData,
   output logic                  enc_dec,
`ifdef SIMON_LOADER_KEYLOCK_EN
   output logic                  err_nokey,
`endif
   output logic [M-1:0][N-1:0]   KEY,
   output logic [1:0][N-1:0]     blockIN
);

   localparam int unsigned KEY_W      = M * N;
   localparam int unsigned BLK_W      = 2 * N;
   localparam int unsigned KEY_BYTES  = KEY_W / W;
   localparam int unsigned DATA_BYTES = BLK_W / W;

   // Parameter sanity: whole bytes per word, and a counter wide enough for a key
   if (((BLK_W % W) != 0) || ((KEY_W % W) != 0)) begin : g_bad_width
      $error("simon_byte_loader: 2*N and M*N must be multiples of W");
   end
   if (KEY_BYTES >= (2 ** CB) || DATA_BYTES >= (2 ** CB)) begin : g_bad_cb
      $error("simon_byte_loader: CB too narrow for the byte count");
   end

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL_KEY  = 3'd1,
      FILL_DATA = 3'd2,
      REQ_KEY   = 3'd3,
      REQ_DATA  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [CB-1:0]      count_q, count_d;
   logic [KEY_W-1:0]   key_q;
   logic [BLK_W-1:0]   blk_q;
   logic               in_ready_q, new_key_q, new_data_q, enc_dec_q;
   logic               xfer;
   logic               shift_key, shift_data, latch_dir;
   logic               key_done;

`ifdef SIMON_LOADER_KEYLOCK_EN
   logic               key_seen_q;
   logic               err_q, err_d;
`endif

   assign xfer = in_valid & in_ready_q;

   // Next-state and datapath enables
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      shift_key  = 1'b0;
      shift_data = 1'b0;
      latch_dir  = 1'b0;
      key_done   = 1'b0;
`ifdef SIMON_LOADER_KEYLOCK_EN
      err_d      = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (flush) begin
               count_d = '0;
            end else if (xfer) begin
               if (in_is_key) begin
                  shift_key = 1'b1;
                  count_d   = CB'(1);
                  state_d   = (KEY_BYTES == 1) ? REQ_KEY : FILL_KEY;
`ifdef SIMON_LOADER_KEYLOCK_EN
               end else if (!key_seen_q) begin
                  // Data before any loaded key: swallow the byte and flag it
                  err_d = 1'b1;
`endif
               end else begin
                  shift_data = 1'b1;
                  latch_dir  = 1'b1;
                  count_d    = CB'(1);
                  state_d    = (DATA_BYTES == 1) ? REQ_DATA : FILL_DATA;
               end
            end
         end
         FILL_KEY: begin
            if (flush) begin
               count_d = '0;
               state_d = IDLE;
            end else if (xfer) begin
               shift_key = 1'b1;
               count_d   = count_q + CB'(1);
               if (count_q == CB'(KEY_BYTES - 1)) state_d = REQ_KEY;
            end
         end
         FILL_DATA: begin
            if (flush) begin
               count_d = '0;
               state_d = IDLE;
            end else if (xfer) begin
               shift_data = 1'b1;
               count_d    = count_q + CB'(1);
               if (count_q == CB'(DATA_BYTES - 1)) state_d = REQ_DATA;
            end
         end
         REQ_KEY: begin
            if (loadKey) begin
               key_done = 1'b1;
               count_d  = '0;
               state_d  = IDLE;
            end
         end
         REQ_DATA: begin
            if (loadData) begin
               count_d = '0;
               state_d = IDLE;
            end
         end
         default: begin
            count_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State register; handshake outputs are registered from the next state
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         state_q    <= IDLE;
         count_q    <= '0;
         in_ready_q <= 1'b1;
         new_key_q  <= 1'b0;
         new_data_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         in_ready_q <= (state_d != REQ_KEY) && (state_d != REQ_DATA);
         new_key_q  <= (state_d == REQ_KEY);
         new_data_q <= (state_d == REQ_DATA);
      end
   end

   // Shift registers: each accepted byte enters at the LSB end
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         key_q     <= '0;
         blk_q     <= '0;
         enc_dec_q <= 1'b0;
      end else begin
         if (shift_key)  key_q     <= {key_q[KEY_W-W-1:0], in_byte};
         if (shift_data) blk_q     <= {blk_q[BLK_W-W-1:0], in_byte};
         if (latch_dir)  enc_dec_q <= in_enc_dec;
      end
   end

`ifdef SIMON_LOADER_KEYLOCK_EN
   // Key-seen flag is sticky until reset
   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         key_seen_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (key_done) key_seen_q <= 1'b1;
         err_q <= err_d;
      end
   end
   assign err_nokey = err_q;
`else
   logic unused_key_done;
   assign unused_key_done = key_done;
`endif

   assign in_ready = in_ready_q;
   assign newKey   = new_key_q;
   assign newData  = new_data_q;
   assign enc_dec  = enc_dec_q;
   assign KEY      = key_q;
   assign blockIN  = blk_q;

endmodule
